// File: rtl/vending_core.sv
// Vending machine transaction controller: client sessions, coin credit,
// change reserve accounting and per-client loyalty points.
module vending_core #(
    parameter int unsigned NUM_ITEMS      = 10,
    parameter int unsigned MAX_CLIENTS    = 100,
    parameter int unsigned PRICE_STEP     = 10,
    parameter int unsigned CHANGE_RESERVE = 500,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [8:0]           client_id,
    input  logic [5:0]           coin_in,
    input  logic [1:0]           currency_type,
    input  logic                 coin_insert,
    input  logic [NUM_ITEMS-1:0] item_select,
    input  logic                 confirm,
    output logic [NUM_ITEMS-1:0] item_out,
    output logic [31:0]          change_out,
    output logic                 no_change,
    output logic [7:0]           client_points
);
    localparam int unsigned ID_W  = (MAX_CLIENTS > 1) ? $clog2(MAX_CLIENTS) : 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SESSION,
        PAY
    } state_t;

    state_t           state;
    logic [ID_W-1:0]  active_id;
    logic [31:0]      credit;
    logic [31:0]      reserve;
    logic [TMR_W-1:0] timer;
    logic [7:0]       points [MAX_CLIENTS];

    logic [31:0] coin_value;
    logic [32:0] credit_wide;
    logic [32:0] reserve_wide;
    logic [31:0] credit_sum;
    logic [31:0] reserve_sum;
    logic [31:0] price;
    logic [31:0] change;
    logic [31:0] headroom;
    int unsigned sel_count;
    int unsigned sel_idx;
    logic        id_ok;
    logic [7:0]  pts_cur;
    logic [7:0]  pts_inc;

    always_comb begin
        sel_count = 0;
        sel_idx   = 0;
        for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
            if (item_select[i]) begin
                sel_count = sel_count + 1;
                sel_idx   = i;
            end
        end
        price = PRICE_STEP * (sel_idx + 1);

        case (currency_type)
            2'd0:    coin_value = {26'd0, coin_in};
            2'd1:    coin_value = {25'd0, coin_in, 1'b0};
            2'd2:    coin_value = {26'd0, coin_in} * 32'd5;
            default: coin_value = '0;
        endcase

        // Both accumulators clamp at all-ones instead of wrapping.
        credit_wide  = {1'b0, credit} + {1'b0, coin_value};
        reserve_wide = {1'b0, reserve} + {1'b0, coin_value};
        credit_sum   = credit_wide[32] ? '1 : credit_wide[31:0];
        reserve_sum  = reserve_wide[32] ? '1 : reserve_wide[31:0];

        change   = credit - price;
        headroom = reserve - credit;
        id_ok    = 32'(client_id) < MAX_CLIENTS;
        pts_cur  = points[active_id];
        pts_inc  = (pts_cur == 8'hFF) ? pts_cur : pts_cur + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            active_id     <= '0;
            credit        <= '0;
            reserve       <= CHANGE_RESERVE;
            timer         <= '0;
            item_out      <= '0;
            change_out    <= '0;
            no_change     <= 1'b0;
            client_points <= '0;
            for (int unsigned i = 0; i < MAX_CLIENTS; i++) begin
                points[i] <= '0;
            end
        end else begin
            item_out   <= '0;
            change_out <= '0;
            no_change  <= 1'b0;
            case (state)
                IDLE: begin
                    if (id_valid && id_ok) begin
                        state         <= SESSION;
                        active_id     <= client_id[ID_W-1:0];
                        credit        <= '0;
                        timer         <= '0;
                        client_points <= points[client_id[ID_W-1:0]];
                    end
                end
                SESSION: begin
                    if (coin_insert) begin
                        timer <= '0;
                        if (currency_type != 2'd3) begin
                            credit  <= credit_sum;
                            reserve <= reserve_sum;
                        end
                    end else if (confirm) begin
                        timer <= '0;
                        if (sel_count == 0) begin
                            change_out <= credit;
                            reserve    <= reserve - credit;
                            credit     <= '0;
                            state      <= PAY;
                        end else if (sel_count == 1 && credit >= price) begin
                            // Change may only come from money held before this session.
                            if (change > headroom) begin
                                no_change <= 1'b1;
                            end else begin
                                item_out           <= item_select;
                                change_out         <= change;
                                reserve            <= reserve - change;
                                points[active_id]  <= pts_inc;
                                client_points      <= pts_inc;
                                credit             <= '0;
                                state              <= PAY;
                            end
                        end
                    end else if (timer == TMR_MAX) begin
                        change_out <= credit;
                        reserve    <= reserve - credit;
                        credit     <= '0;
                        state      <= PAY;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: begin
                    state         <= IDLE;
                    client_points <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vending_core.sv
// Self-checking bench for vending_core: directed scenarios plus randomized
// sessions compared cycle by cycle against a transaction-level model.
module tb_vending_core;
    localparam int TIMEOUT = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, coin_insert, confirm;
    logic [8:0] client_id;
    logic [5:0] coin_in;
    logic [1:0] currency_type;
    logic [9:0] item_select;
    logic [9:0] item_out;
    logic [31:0] change_out;
    logic        no_change;
    logic [7:0]  client_points;

    logic       b_id_valid, b_coin_insert, b_confirm;
    logic [8:0] b_client_id;
    logic [5:0] b_coin_in;
    logic [1:0] b_currency_type;
    logic [9:0] b_item_select;
    logic [9:0] b_item_out;
    logic [31:0] b_change_out;
    logic        b_no_change;
    logic [7:0]  b_client_points;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vending_core #(.NUM_ITEMS(10), .MAX_CLIENTS(100), .PRICE_STEP(10),
                   .CHANGE_RESERVE(500), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .client_id(client_id),
        .coin_in(coin_in), .currency_type(currency_type), .coin_insert(coin_insert),
        .item_select(item_select), .confirm(confirm), .item_out(item_out),
        .change_out(change_out), .no_change(no_change), .client_points(client_points));

    vending_core #(.NUM_ITEMS(10), .MAX_CLIENTS(100), .PRICE_STEP(10),
                   .CHANGE_RESERVE(0), .TIMEOUT_CYCLES(TIMEOUT)) dut_b (
        .clk(clk), .rst(rst), .id_valid(b_id_valid), .client_id(b_client_id),
        .coin_in(b_coin_in), .currency_type(b_currency_type), .coin_insert(b_coin_insert),
        .item_select(b_item_select), .confirm(b_confirm), .item_out(b_item_out),
        .change_out(b_change_out), .no_change(b_no_change), .client_points(b_client_points));

    // Transaction-level model of the default-parameter instance.
    bit              m_in_session, m_paying;
    longint unsigned m_credit, m_reserve;
    int              m_idle, m_client;
    int              m_points [100];
    logic [9:0]      e_item;
    logic [31:0]     e_change;
    logic            e_nochg;
    logic [7:0]      e_pts;
    int              rate [3] = '{1, 2, 5};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_in_session = 0; m_paying = 0; m_credit = 0; m_reserve = 500; m_idle = 0; m_client = 0;
        foreach (m_points[i]) m_points[i] = 0;
        e_item = '0; e_change = '0; e_nochg = 1'b0; e_pts = '0;
    endtask

    function automatic longint unsigned clamp32(input longint unsigned x);
        return (x > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : x;
    endfunction

    task automatic refund();
        e_change = 32'(m_credit);
        m_reserve -= m_credit;
        m_credit = 0;
        m_in_session = 0;
        m_paying = 1;
    endtask

    task automatic model_step();
        int n, idx;
        longint unsigned price, chg;
        e_item = '0; e_change = '0; e_nochg = 1'b0;
        if (m_paying) begin
            m_paying = 0;
            e_pts = '0;
        end else if (!m_in_session) begin
            if (id_valid && client_id < 100) begin
                m_in_session = 1; m_client = int'(client_id); m_credit = 0; m_idle = 0;
                e_pts = 8'(m_points[m_client]);
            end
        end else if (coin_insert) begin
            m_idle = 0;
            if (currency_type != 2'd3) begin
                m_credit  = clamp32(m_credit + coin_in * rate[currency_type]);
                m_reserve = clamp32(m_reserve + coin_in * rate[currency_type]);
            end
        end else if (confirm) begin
            m_idle = 0;
            n = $countones(item_select);
            idx = 0;
            for (int i = 0; i < 10; i++) if (item_select[i]) idx = i;
            price = 10 * (idx + 1);
            if (n == 0) refund();
            else if (n == 1 && m_credit >= price) begin
                chg = m_credit - price;
                if (chg > m_reserve - m_credit) e_nochg = 1'b1;
                else begin
                    e_item = item_select;
                    e_change = 32'(chg);
                    m_reserve -= chg;
                    if (m_points[m_client] < 255) m_points[m_client]++;
                    e_pts = 8'(m_points[m_client]);
                    m_credit = 0;
                    m_in_session = 0;
                    m_paying = 1;
                end
            end
        end else if (m_idle == TIMEOUT) refund();
        else m_idle++;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("item_out", 64'(item_out), 64'(e_item));
        check("change_out", 64'(change_out), 64'(e_change));
        check("no_change", 64'(no_change), 64'(e_nochg));
        check("client_points", 64'(client_points), 64'(e_pts));
    endtask

    task automatic step(input logic iv, input int cid, input logic ci, input int cv,
                        input int ct, input logic cf, input logic [9:0] sel);
        id_valid = iv; client_id = 9'(cid); coin_insert = ci; coin_in = 6'(cv);
        currency_type = 2'(ct); confirm = cf; item_select = sel;
        cycle();
    endtask

    task automatic idle();
        step(1'b0, 0, 1'b0, 0, 0, 1'b0, '0);
    endtask

    task automatic bstep(input logic iv, input int cid, input logic ci, input int cv,
                         input logic cf, input logic [9:0] sel);
        b_id_valid = iv; b_client_id = 9'(cid); b_coin_insert = ci; b_coin_in = 6'(cv);
        b_currency_type = 2'd0; b_confirm = cf; b_item_select = sel;
        idle();
    endtask

    initial begin
        int n;
        rst = 1'b1;
        id_valid = 0; client_id = '0; coin_insert = 0; coin_in = '0;
        currency_type = '0; confirm = 0; item_select = '0;
        b_id_valid = 0; b_client_id = '0; b_coin_insert = 0; b_coin_in = '0;
        b_currency_type = '0; b_confirm = 0; b_item_select = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_item", 64'(item_out), 0);
        check("rst_change", 64'(change_out), 0);
        check("rst_nochg", 64'(no_change), 0);
        check("rst_points", 64'(client_points), 0);
        rst = 1'b0;

        // Basic purchase: 20 x5 = 100, item 3 costs 40.
        step(1, 5, 0, 0, 0, 0, '0);
        step(0, 0, 1, 20, 2, 0, '0);
        step(0, 0, 0, 0, 0, 1, 10'h008);
        check("buy_item", 64'(item_out), 64'h008);
        check("buy_change", 64'(change_out), 60);
        check("buy_points", 64'(client_points), 1);
        idle();
        check("pay_pulse_end", 64'(item_out), 0);
        idle();
        check("idle_points", 64'(client_points), 0);

        // Out-of-range id ignored; invalid currency adds nothing.
        step(1, 200, 0, 0, 0, 0, '0);
        step(0, 0, 0, 0, 0, 1, '0);
        check("bad_id_no_refund", 64'(change_out), 0);
        step(1, 3, 0, 0, 0, 0, '0);
        step(0, 0, 1, 5, 3, 0, '0);
        step(0, 0, 0, 0, 0, 1, '0);
        check("invalid_coin_cancel", 64'(change_out), 0);
        idle();

        // Inactivity refund after exactly TIMEOUT+1 idle edges.
        step(1, 2, 0, 0, 0, 0, '0);
        step(0, 0, 1, 30, 0, 0, '0);
        n = 0;
        while (n < TIMEOUT + 50) begin
            idle();
            n++;
            if (change_out != 0) break;
        end
        check("timeout_latency", 64'(n), 64'(TIMEOUT + 1));
        check("timeout_refund", 64'(change_out), 30);
        idle();

        // Coin and confirm together: only the coin counts.
        step(1, 4, 0, 0, 0, 0, '0);
        step(0, 0, 1, 10, 1, 1, 10'h001);
        check("coin_wins_item", 64'(item_out), 0);
        step(0, 0, 0, 0, 0, 1, 10'h001);
        check("late_confirm_item", 64'(item_out), 64'h001);
        check("late_confirm_change", 64'(change_out), 10);
        idle();

        // Loyalty points saturate at 255.
        for (int s = 0; s < 256; s++) begin
            step(1, 7, 0, 0, 0, 0, '0);
            step(0, 0, 1, 10, 0, 0, '0);
            step(0, 0, 0, 0, 0, 1, 10'h001);
            idle();
        end
        step(1, 7, 0, 0, 0, 0, '0);
        check("points_saturated", 64'(client_points), 255);
        step(0, 0, 0, 0, 0, 1, '0);
        idle();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            int r;
            id_valid = ($urandom_range(0, 99) < 20);
            client_id = 9'($urandom_range(0, 130));
            coin_insert = ($urandom_range(0, 99) < 30);
            coin_in = 6'($urandom);
            currency_type = 2'($urandom);
            confirm = ($urandom_range(0, 99) < 15);
            r = $urandom_range(0, 99);
            if (r < 15) item_select = '0;
            else if (r < 65) item_select = 10'(1 << $urandom_range(0, 9));
            else item_select = 10'($urandom);
            cycle();
        end
        idle(); idle();

        // Asynchronous reset mid-session discards credit.
        step(1, 5, 0, 0, 0, 0, '0);
        step(0, 0, 1, 40, 0, 0, '0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_points", 64'(client_points), 0);
        check("async_rst_change", 64'(change_out), 0);
        check("async_rst_item", 64'(item_out), 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        step(0, 0, 0, 0, 0, 1, '0);
        check("no_refund_after_rst", 64'(change_out), 0);
        step(1, 5, 0, 0, 0, 0, '0);
        check("points_cleared", 64'(client_points), 0);
        step(0, 0, 0, 0, 0, 1, '0);
        idle();

        // Empty reserve: change cannot be paid.
        bstep(1, 1, 0, 0, 0, '0);
        bstep(0, 0, 1, 50, 0, '0);
        bstep(0, 0, 0, 0, 1, 10'h001);
        check("b_no_change", 64'(b_no_change), 1);
        check("b_no_item", 64'(b_item_out), 0);
        check("b_no_payout", 64'(b_change_out), 0);
        bstep(0, 0, 0, 0, 0, '0);
        check("b_pulse_end", 64'(b_no_change), 0);
        bstep(0, 0, 0, 0, 1, '0);
        check("b_cancel_refund", 64'(b_change_out), 50);
        bstep(0, 0, 0, 0, 0, '0);
        check("b_refund_pulse", 64'(b_change_out), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
